// File: rtl/kiwi_axil_master_biu_if.sv
// AXI-lite bus between the kiwi BIU initiator and its responder.
// One instance per port (fetch or LSU).
interface kiwi_axil_master_biu_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  localparam int STRB_W = DATA_W / 8;

  logic              m_awvalid;
  logic              m_awready;
  logic [ADDR_W-1:0] m_awaddr;
  logic [2:0]        m_awprot;

  logic              m_wvalid;
  logic              m_wready;
  logic [DATA_W-1:0] m_wdata;
  logic [STRB_W-1:0] m_wstrb;

  logic              m_bvalid;
  logic              m_bready;
  logic [1:0]        m_bresp;

  logic              m_arvalid;
  logic              m_arready;
  logic [ADDR_W-1:0] m_araddr;
  logic [2:0]        m_arprot;

  logic              m_rvalid;
  logic              m_rready;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0]        m_rresp;

  modport master (
    output m_awvalid, m_awaddr, m_awprot,
    input  m_awready,
    output m_wvalid, m_wdata, m_wstrb,
    input  m_wready,
    input  m_bvalid, m_bresp,
    output m_bready,
    output m_arvalid, m_araddr, m_arprot,
    input  m_arready,
    input  m_rvalid, m_rdata, m_rresp,
    output m_rready
  );

  modport slave (
    input  m_awvalid, m_awaddr, m_awprot,
    output m_awready,
    input  m_wvalid, m_wdata, m_wstrb,
    output m_wready,
    output m_bvalid, m_bresp,
    input  m_bready,
    input  m_arvalid, m_araddr, m_arprot,
    output m_arready,
    output m_rvalid, m_rdata, m_rresp,
    input  m_rready
  );
endinterface

// File: rtl/kiwi_axil_master_biu.sv
// AXI-lite initiator BIU: core req/rsp port to one AXI-lite master.
// Single outstanding transaction, Moore-style channel valids.
module kiwi_axil_master_biu #(
  parameter int          ADDR_W = 64,
  parameter int          DATA_W = 64,
  parameter int          STRB_W = DATA_W / 8,
  parameter logic [2:0]  PROT   = 3'b000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  kiwi_axil_master_biu_if.master m
);

  typedef enum logic [2:0] {
    IDLE, RD_A, RD_D, WR_AW, WR_B, RSP
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              aw_done;
  logic              w_done;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic accept;

  assign aw_hs  = m.m_awvalid & m.m_awready;
  assign w_hs   = m.m_wvalid  & m.m_wready;
  assign b_hs   = m.m_bvalid  & m.m_bready;
  assign ar_hs  = m.m_arvalid & m.m_arready;
  assign r_hs   = m.m_rvalid  & m.m_rready;
  assign accept = (state == IDLE) & req_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (req_valid)
               state_nx = req_write ? WR_AW : RD_A;
      RD_A:  if (ar_hs) state_nx = RD_D;
      RD_D:  if (r_hs)  state_nx = RSP;
      WR_AW: if ((aw_done | aw_hs) & (w_done | w_hs))
               state_nx = WR_B;
      WR_B:  if (b_hs) state_nx = RSP;
      RSP:   if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (r_hs) begin
        rdata_q <= m.m_rdata;
        err_q   <= |m.m_rresp;
      end
      if (b_hs) begin
        rdata_q <= '0;
        err_q   <= |m.m_bresp;
      end
    end
  end

  // Outputs decode from registered state only, never from a ready.
  assign req_ready = rst_n & (state == IDLE);
  assign rsp_valid = (state == RSP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign m.m_arvalid = (state == RD_A);
  assign m.m_araddr  = addr_q;
  assign m.m_arprot  = PROT;
  assign m.m_rready  = (state == RD_D);

  assign m.m_awvalid = (state == WR_AW) & ~aw_done;
  assign m.m_awaddr  = addr_q;
  assign m.m_awprot  = PROT;
  assign m.m_wvalid  = (state == WR_AW) & ~w_done;
  assign m.m_wdata   = wdata_q;
  assign m.m_wstrb   = wstrb_q;
  assign m.m_bready  = (state == WR_B);

endmodule

// File: tb/tb_kiwi_axil_master_biu.sv
// Bench for kiwi_axil_master_biu: delay-programmable AXI-lite responder
// with its own memory, plus a word-level reference memory for checking.
module tb_kiwi_axil_master_biu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  kiwi_axil_master_biu_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  kiwi_axil_master_biu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .m         (bus.master)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] init_word(input logic [63:0] a);
    return {a[31:0] ^ 32'h5A5A_0000, ~a[31:0]};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] o,
                                        input logic [63:0] d,
                                        input logic [7:0]  s);
    logic [63:0] r;
    r = o;
    for (int i = 0; i < 8; i++)
      if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  // Responder side state and memory
  int ar_dly = 0, aw_dly = 0, w_dly = 0;
  int r_dly = 0, b_dly = 0;
  int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
  int b_issued = 0;
  logic        r_pend, b_pend, got_aw, got_w;
  logic [63:0] aw_a, w_d, r_data_q;
  logic [7:0]  w_s;
  logic [1:0]  r_resp_q, b_resp_q;
  logic        ga, gw;
  logic [63:0] ca, cd;
  logic [7:0]  cs;
  logic [63:0] smem [logic [60:0]];

  function automatic logic [63:0] s_rd(input logic [63:0] a);
    if (smem.exists(a[63:3])) return smem[a[63:3]];
    return init_word(a);
  endfunction

  assign bus.m_arready = (ar_cnt >= ar_dly);
  assign bus.m_awready = !got_aw && (aw_cnt >= aw_dly);
  assign bus.m_wready  = !got_w && (w_cnt >= w_dly);
  assign bus.m_rvalid  = r_pend && (r_cnt >= r_dly);
  assign bus.m_rdata   = r_data_q;
  assign bus.m_rresp   = r_resp_q;
  assign bus.m_bvalid  = b_pend && (b_cnt >= b_dly);
  assign bus.m_bresp   = b_resp_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0;
      r_cnt <= 0; b_cnt <= 0;
      r_pend <= 0; b_pend <= 0;
      got_aw <= 0; got_w <= 0;
      aw_a <= '0; w_d <= '0; w_s <= '0;
      r_data_q <= '0; r_resp_q <= '0; b_resp_q <= '0;
    end else begin
      if (bus.m_arvalid && bus.m_arready) begin
        ar_cnt   <= 0;
        r_pend   <= 1;
        r_cnt    <= 0;
        r_data_q <= s_rd(bus.m_araddr);
        r_resp_q <= bus.m_araddr[63] ? 2'b10 : 2'b00;
      end else if (bus.m_arvalid) ar_cnt <= ar_cnt + 1;
      if (r_pend) begin
        if (bus.m_rvalid && bus.m_rready) r_pend <= 0;
        else r_cnt <= r_cnt + 1;
      end
      if (bus.m_awvalid && bus.m_awready) begin
        aw_cnt <= 0; got_aw <= 1; aw_a <= bus.m_awaddr;
      end else if (bus.m_awvalid) aw_cnt <= aw_cnt + 1;
      if (bus.m_wvalid && bus.m_wready) begin
        w_cnt <= 0; got_w <= 1;
        w_d <= bus.m_wdata; w_s <= bus.m_wstrb;
      end else if (bus.m_wvalid) w_cnt <= w_cnt + 1;
      ga = got_aw || (bus.m_awvalid && bus.m_awready);
      gw = got_w || (bus.m_wvalid && bus.m_wready);
      ca = got_aw ? aw_a : bus.m_awaddr;
      cd = got_w ? w_d : bus.m_wdata;
      cs = got_w ? w_s : bus.m_wstrb;
      if (ga && gw && !b_pend) begin
        got_aw <= 0; got_w <= 0;
        b_pend <= 1; b_cnt <= 0;
        b_resp_q <= ca[63] ? 2'b10 : 2'b00;
        if (!ca[63]) smem[ca[63:3]] = merge(s_rd(ca), cd, cs);
        b_issued <= b_issued + 1;
      end
      if (b_pend) begin
        if (bus.m_bvalid && bus.m_bready) b_pend <= 0;
        else b_cnt <= b_cnt + 1;
      end
    end
  end

  // Protocol watcher: exclusivity, valid hold and payload stability
  int proto_bad = 0;
  logic p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
  logic [63:0] p_ara, p_awa, p_wd;
  logic [7:0]  p_ws;

  always @(posedge clk) begin
    if (!rst_n) begin
      p_arv <= 0; p_arr <= 0; p_awv <= 0;
      p_awr <= 0; p_wv <= 0; p_wr <= 0;
    end else begin
      if (bus.m_arvalid && bus.m_awvalid) proto_bad <= proto_bad + 1;
      if (bus.m_arvalid && bus.m_arprot != 3'b000) proto_bad <= proto_bad + 1;
      if (bus.m_awvalid && bus.m_awprot != 3'b000) proto_bad <= proto_bad + 1;
      if (p_arv && !p_arr &&
          (!bus.m_arvalid || bus.m_araddr != p_ara))
        proto_bad <= proto_bad + 1;
      if (p_awv && !p_awr &&
          (!bus.m_awvalid || bus.m_awaddr != p_awa))
        proto_bad <= proto_bad + 1;
      if (p_wv && !p_wr &&
          (!bus.m_wvalid || bus.m_wdata != p_wd || bus.m_wstrb != p_ws))
        proto_bad <= proto_bad + 1;
      p_arv <= bus.m_arvalid; p_arr <= bus.m_arready;
      p_awv <= bus.m_awvalid; p_awr <= bus.m_awready;
      p_wv  <= bus.m_wvalid;  p_wr  <= bus.m_wready;
      p_ara <= bus.m_araddr;  p_awa <= bus.m_awaddr;
      p_wd  <= bus.m_wdata;   p_ws  <= bus.m_wstrb;
    end
  end

  // Reference memory at word granularity
  logic [63:0] mmem [logic [60:0]];

  function automatic logic [63:0] m_rd(input logic [63:0] a);
    if (mmem.exists(a[63:3])) return mmem[a[63:3]];
    return init_word(a);
  endfunction

  task automatic m_wr(input logic [63:0] a, input logic [63:0] d,
                      input logic [7:0] s);
    if (!a[63]) mmem[a[63:3]] = merge(m_rd(a), d, s);
  endtask

  int aw_gap, ar_cyc, hold_bad;

  task automatic do_op(input logic w, input logic [63:0] a,
                       input logic [63:0] d, input logic [7:0] s,
                       input int hold, input logic keep_req,
                       output logic [63:0] rd, output logic e,
                       output int lat);
    int t;
    @(negedge clk);
    req_valid = 1; req_write = w;
    req_addr = a; req_wdata = d; req_wstrb = s;
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk); t++;
    end
    chk("accept", {63'd0, req_ready}, 64'd1);
    aw_gap = 0; ar_cyc = 0;
    @(negedge clk);
    req_valid = keep_req;
    lat = 1; t = 0;
    while (!rsp_valid && t < 100) begin
      if (!bus.m_awvalid && bus.m_wvalid) aw_gap++;
      if (bus.m_arvalid) ar_cyc++;
      @(negedge clk); lat++; t++;
    end
    chk("rsp_seen", {63'd0, rsp_valid}, 64'd1);
    rd = rsp_rdata; e = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== rd || rsp_err !== e ||
          req_ready || bus.m_arvalid || bus.m_awvalid)
        hold_bad++;
    end
    rsp_ready = 1; req_valid = 0;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  logic [63:0] rd, exp_d, a, d;
  logic [7:0]  s;
  logic        e, w, exp_e;
  int          lat, b0, t, stray;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_valids", {58'd0, bus.m_arvalid, bus.m_awvalid,
        bus.m_wvalid, bus.m_rready, bus.m_bready, rsp_valid}, 64'd0);
    rst_n = 1;
    @(negedge clk);
    chk("idle_req_ready", {63'd0, req_ready}, 64'd1);
    chk("idle_rsp", {rsp_rdata[62:0], rsp_err}, 64'd0);

    // zero-wait read, latency and data
    smem[61'(64'h1000 >> 3)] = 64'hDEADBEEF_CAFEF00D;
    mmem[61'(64'h1000 >> 3)] = 64'hDEADBEEF_CAFEF00D;
    do_op(0, 64'h1000, 0, 0, 0, 0, rd, e, lat);
    chk("t1_latency", lat, 3);
    chk("t1_rdata", rd, 64'hDEADBEEF_CAFEF00D);
    chk("t1_err", {63'd0, e}, 64'd0);

    // AW accepted 3 cycles ahead of W
    b0 = b_issued;
    aw_dly = 1; w_dly = 4;
    do_op(1, 64'h2008, 64'h1122334455667788, 8'h0F, 0, 0, rd, e, lat);
    m_wr(64'h2008, 64'h1122334455667788, 8'h0F);
    chk("t2_aw_gap", aw_gap, 3);
    chk("t2_b_count", b_issued - b0, 1);
    chk("t2_err", {63'd0, e}, 64'd0);
    chk("t2_rdata", rd, 64'd0);
    aw_dly = 0; w_dly = 0;
    do_op(0, 64'h2008, 0, 0, 0, 0, rd, e, lat);
    chk("t2_readback", rd, m_rd(64'h2008));

    // stalled AR, SLVERR response
    ar_dly = 5;
    do_op(0, 64'h8000_0000_0000_3000, 0, 0, 0, 0, rd, e, lat);
    chk("t3_ar_cycles", ar_cyc, 6);
    chk("t3_err", {63'd0, e}, 64'd1);
    chk("t3_rdata", rd, m_rd(64'h8000_0000_0000_3000));
    ar_dly = 0;

    // response backpressure with a pending request
    hold_bad = 0;
    do_op(0, 64'h1000, 0, 0, 4, 1, rd, e, lat);
    chk("t4_hold", hold_bad, 0);
    chk("t4_rdata", rd, 64'hDEADBEEF_CAFEF00D);

    // reset while waiting in the read-data phase
    r_dly = 20;
    @(negedge clk);
    req_valid = 1; req_write = 0; req_addr = 64'h1000;
    @(negedge clk);
    req_valid = 0;
    t = 0;
    while (!bus.m_rready && t < 20) begin
      @(negedge clk); t++;
    end
    chk("t5_in_rd_d", {63'd0, bus.m_rready}, 64'd1);
    #2 rst_n = 0;
    #1;
    chk("t5_drop", {57'd0, bus.m_arvalid, bus.m_awvalid,
        bus.m_wvalid, bus.m_rready, bus.m_bready,
        rsp_valid, req_ready}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1; r_dly = 0;
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid || !req_ready) stray++;
    end
    chk("t5_after", stray, 0);

    // random back-to-back traffic against the reference memory
    for (int i = 0; i < 100; i++) begin
      ar_dly = $urandom_range(0, 3);
      aw_dly = $urandom_range(0, 3);
      w_dly  = $urandom_range(0, 3);
      r_dly  = $urandom_range(0, 3);
      b_dly  = $urandom_range(0, 3);
      a = 64'h4000 + 64'($urandom_range(0, 15)) * 8;
      if ($urandom_range(0, 7) == 0) a[63] = 1'b1;
      w = 1'($urandom_range(0, 1));
      d = {$urandom, $urandom};
      s = 8'($urandom);
      exp_e = a[63];
      exp_d = w ? 64'd0 : m_rd(a);
      if (w) m_wr(a, d, s);
      do_op(w, a, d, s, $urandom_range(0, 2), 0, rd, e, lat);
      chk($sformatf("rnd%0d_rdata", i), rd, exp_d);
      chk($sformatf("rnd%0d_err", i), {63'd0, e}, {63'd0, exp_e});
    end

    chk("protocol", proto_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
